// File: rtl/instr_fetch_unit_if.sv
// Instruction memory bus between the fetch unit and instruction memory.
// The request channel is valid/ready. The response channel is valid only:
// memory returns responses in order, one for each accepted request.
//   imem_req_valid  : fetch request valid              (fetch unit -> memory)
//   imem_req_addr   : word-aligned fetch address       (fetch unit -> memory)
//   imem_req_ready  : memory accepts the request       (memory -> fetch unit)
//   imem_resp_valid : response valid                   (memory -> fetch unit)
//   imem_resp_data  : fetched instruction word         (memory -> fetch unit)
interface instr_fetch_unit_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage. It keeps at most one request outstanding to
// instruction memory. It holds each returned instruction until the pipeline
// consumes it (stall low), and a redirect squashes any in-flight fetch.
// Ports:
//   clk, reset        : clock and asynchronous active-high reset
//   stall             : IF/ID hold; 1 = the held instruction is not consumed
//   redirect_valid/pc : taken branch/jump target; bits [1:0] are ignored
//   imem              : instruction memory bus (master side)
//   PC_out            : PC of the held instruction
//   instruction_out   : held instruction, or NOP_INSTR when nothing is held
//   fetch_valid       : a real instruction is held
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  instr_fetch_unit_if.master        imem,
  output logic [31:0]               PC_out,
  output logic [31:0]               instruction_out,
  output logic                      fetch_valid
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FULL} state_t;

  state_t      state, state_next;
  logic [31:0] fetch_pc, fetch_pc_next;
  logic        buf_valid, buf_valid_next;
  logic [31:0] buf_pc, buf_pc_next;
  logic [31:0] buf_instr, buf_instr_next;
  logic        drop_pending, drop_pending_next;

  // Redirect targets are always word aligned; the low bits are dropped.
  logic [31:0] redirect_target;
  logic        unused_redirect_bits;
  assign redirect_target      = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_bits = ^redirect_pc[1:0];

  // Register bank for the FSM, fetch address and holding buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      fetch_pc     <= RESET_PC;
      buf_valid    <= 1'b0;
      buf_pc       <= 32'h0000_0000;
      buf_instr    <= NOP_INSTR;
      drop_pending <= 1'b0;
    end else begin
      state        <= state_next;
      fetch_pc     <= fetch_pc_next;
      buf_valid    <= buf_valid_next;
      buf_pc       <= buf_pc_next;
      buf_instr    <= buf_instr_next;
      drop_pending <= drop_pending_next;
    end
  end

  // Next-state logic. A redirect has priority over everything, including
  // stall. If a request has already been accepted at the old address, its
  // response is still owed, and drop_pending marks it to be discarded.
  always_comb begin
    state_next        = state;
    fetch_pc_next     = fetch_pc;
    buf_valid_next    = buf_valid;
    buf_pc_next       = buf_pc;
    buf_instr_next    = buf_instr;
    drop_pending_next = drop_pending;

    if (redirect_valid) begin
      fetch_pc_next  = redirect_target;
      buf_valid_next = 1'b0;
      case (state)
        S_REQ: begin
          if (imem.imem_req_ready) begin
            state_next        = S_WAIT;
            drop_pending_next = 1'b1;
          end else begin
            state_next = S_REQ;
          end
        end
        S_WAIT: begin
          if (imem.imem_resp_valid) begin
            state_next        = S_REQ;
            drop_pending_next = 1'b0;
          end else begin
            state_next        = S_WAIT;
            drop_pending_next = 1'b1;
          end
        end
        default: state_next = S_REQ;
      endcase
    end else begin
      case (state)
        S_IDLE: state_next = S_REQ;
        S_REQ: begin
          if (imem.imem_req_ready) state_next = S_WAIT;
        end
        S_WAIT: begin
          if (imem.imem_resp_valid) begin
            if (drop_pending) begin
              drop_pending_next = 1'b0;
              state_next        = S_REQ;
            end else begin
              buf_pc_next    = fetch_pc;
              buf_instr_next = imem.imem_resp_data;
              buf_valid_next = 1'b1;
              state_next     = S_FULL;
            end
          end
        end
        S_FULL: begin
          // IF/ID captures the held instruction at this edge.
          if (!stall) begin
            buf_valid_next = 1'b0;
            fetch_pc_next  = fetch_pc + 32'd4;
            state_next     = S_REQ;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  assign imem.imem_req_valid = (state == S_REQ);
  assign imem.imem_req_addr  = fetch_pc;
  assign PC_out              = buf_pc;
  assign instruction_out     = buf_valid ? buf_instr : NOP_INSTR;
  assign fetch_valid         = buf_valid;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit. A behavioural memory returns addr^DATA_KEY
// with a programmable latency. A program-counter model tracks which PC the
// pipeline should see next: it steps by 4 on each consumption and jumps on a
// redirect. Directed phases follow the timing scenarios. A randomized phase
// then exercises stall, redirect and ready together. A second instance with
// RESET_PC=FFFF_FFFC checks address wrap.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC   = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] DATA_KEY  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stallIn = 1'b0;
  logic        redirValid = 1'b0;
  logic [31:0] redirPc = 32'h0;
  logic        readyIn = 1'b0;
  int          memLat = 1;

  int testsRun = 0;
  int testsFailed = 0;
  int consumed = 0;
  logic checkEn = 1'b0;

  logic [31:0] pcOut, instrOut;
  logic        fetchValid;
  logic [31:0] wrapPcOut, wrapInstrOut;
  logic        wrapFetchValid;

  instr_fetch_unit_if memIf ();
  instr_fetch_unit_if wrapIf ();

  instr_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .reset(reset), .stall(stallIn),
    .redirect_valid(redirValid), .redirect_pc(redirPc),
    .imem(memIf),
    .PC_out(pcOut), .instruction_out(instrOut), .fetch_valid(fetchValid)
  );

  instr_fetch_unit #(.RESET_PC(WRAP_PC), .NOP_INSTR(NOP_INSTR)) u_wrap (
    .clk(clk), .reset(reset), .stall(1'b0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem(wrapIf),
    .PC_out(wrapPcOut), .instruction_out(wrapInstrOut), .fetch_valid(wrapFetchValid)
  );

  always #5 clk = ~clk;

  // Behavioural memory for the main instance. It holds at most one pending
  // response, answers after memLat cycles and drops any in-flight response
  // on reset.
  logic        memBusy;
  logic [31:0] memAddr;
  int          memCount;
  assign memIf.imem_req_ready  = readyIn;
  assign memIf.imem_resp_valid = memBusy && (memCount == 0);
  assign memIf.imem_resp_data  = memBusy ? (memAddr ^ DATA_KEY) : 32'hDEAD_BEEF;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      memBusy  <= 1'b0;
      memAddr  <= 32'h0;
      memCount <= 0;
    end else if (memIf.imem_req_valid && readyIn) begin
      memBusy  <= 1'b1;
      memAddr  <= memIf.imem_req_addr;
      memCount <= memLat - 1;
    end else if (memBusy) begin
      if (memCount == 0) memBusy <= 1'b0;
      else memCount <= memCount - 1;
    end
  end

  // The wrap instance's memory is always ready and has a fixed 1-cycle latency.
  logic        wrapRespValid;
  logic [31:0] wrapRespData;
  assign wrapIf.imem_req_ready  = 1'b1;
  assign wrapIf.imem_resp_valid = wrapRespValid;
  assign wrapIf.imem_resp_data  = wrapRespData;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wrapRespValid <= 1'b0;
      wrapRespData  <= 32'h0;
    end else begin
      wrapRespValid <= wrapIf.imem_req_valid;
      wrapRespData  <= wrapIf.imem_req_addr ^ DATA_KEY;
    end
  end

  // Program-counter model: the next PC the pipeline should receive.
  logic [31:0] expPc;
  always @(posedge clk or posedge reset) begin
    if (reset) expPc <= RESET_PC;
    else if (redirValid) expPc <= {redirPc[31:2], 2'b00};
    else if (fetchValid && !stallIn) expPc <= expPc + 32'd4;
  end

  always @(posedge clk) begin
    if (!reset && !redirValid && fetchValid && !stallIn) consumed <= consumed + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Applies inputs at the current falling edge and advances to the next
  // falling edge. The outputs then reflect the rising edge in between.
  task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rpc,
                               input logic rdy, input int lat);
    stallIn    = s;
    redirValid = r;
    redirPc    = rpc;
    readyIn    = rdy;
    memLat     = lat;
    @(negedge clk);
  endtask

  // Checks applied on every cycle. A held instruction must be the model's
  // next PC with its memory data. Every request must target the model's next
  // PC, and no request may be issued while a response is still owed.
  always @(negedge clk) begin
    if (checkEn && !reset) begin
      if (fetchValid) begin
        checkOutput("heldPc", pcOut, expPc);
        checkOutput("heldInstr", instrOut, expPc ^ DATA_KEY);
      end else begin
        checkOutput("bubble", instrOut, NOP_INSTR);
      end
      if (memIf.imem_req_valid) begin
        checkOutput("reqAddr", memIf.imem_req_addr, expPc);
        checkOutput("oneOutstanding", {31'b0, memBusy}, 32'h0);
      end
    end
  end

  initial begin
    int guard;
    repeat (2) @(negedge clk);
    checkOutput("rstReqValid", {31'b0, memIf.imem_req_valid}, 32'h0);
    checkOutput("rstPc", pcOut, 32'h0);
    checkOutput("rstInstr", instrOut, NOP_INSTR);
    checkOutput("rstFetchValid", {31'b0, fetchValid}, 32'h0);
    checkOutput("rstWrapAddr", wrapIf.imem_req_addr, WRAP_PC);
    checkEn = 1'b1;
    reset = 1'b0;

    // Always-ready memory with 1-cycle latency gives one instruction every
    // 3 cycles. Requests appear on edges 1, 4, 7 and instructions on 3, 6, 9.
    for (int n = 1; n <= 12; n++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1);
      checkOutput("seqReqValid", {31'b0, memIf.imem_req_valid}, {31'b0, (n % 3) == 1});
      checkOutput("seqFetchValid", {31'b0, fetchValid}, {31'b0, (n % 3) == 0});
      if ((n % 3) == 1) checkOutput("seqReqAddr", memIf.imem_req_addr, 32'(4 * ((n - 1) / 3)));
      if ((n % 3) == 0) begin
        checkOutput("seqPc", pcOut, 32'(4 * (n / 3 - 1)));
        checkOutput("seqInstr", instrOut, 32'(4 * (n / 3 - 1)) ^ DATA_KEY);
      end
      if (n == 1) checkOutput("wrapFirstReq", wrapIf.imem_req_addr, WRAP_PC);
      if (n == 3) begin
        checkOutput("wrapPc", wrapPcOut, WRAP_PC);
        checkOutput("wrapInstr", wrapInstrOut, WRAP_PC ^ DATA_KEY);
      end
      if (n == 4) begin
        checkOutput("wrapReqValid", {31'b0, wrapIf.imem_req_valid}, 32'h1);
        checkOutput("wrapNextAddr", wrapIf.imem_req_addr, 32'h0);
      end
    end

    // Bring 0x10 into the buffer, then stall for 4 cycles.
    repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1);
    checkOutput("preStallPc", pcOut, 32'h10);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1);
      checkOutput("stallHoldValid", {31'b0, fetchValid}, 32'h1);
      checkOutput("stallHoldPc", pcOut, 32'h10);
      checkOutput("stallHoldInstr", instrOut, 32'h10 ^ DATA_KEY);
      checkOutput("stallNoReq", {31'b0, memIf.imem_req_valid}, 32'h0);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 3);
    checkOutput("postStallReqValid", {31'b0, memIf.imem_req_valid}, 32'h1);
    checkOutput("postStallReqAddr", memIf.imem_req_addr, 32'h14);

    // Redirect to 0x200 while in WAIT. The response to 0x14 arrives two
    // cycles later and must be discarded.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 3);
    applyStimulus(1'b0, 1'b1, 32'h200, 1'b1, 1);
    checkOutput("redirWaitNoReq", {31'b0, memIf.imem_req_valid}, 32'h0);
    guard = 0;
    while (!memIf.imem_req_valid && guard < 10) begin
      checkOutput("redirNoStale", {31'b0, fetchValid}, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1);
      guard++;
    end
    checkOutput("redirReqTimeout", {31'b0, memIf.imem_req_valid}, 32'h1);
    checkOutput("redirReqAddr", memIf.imem_req_addr, 32'h200);
    guard = 0;
    while (!fetchValid && guard < 10) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1);
      guard++;
    end
    checkOutput("redirFetchTimeout", {31'b0, fetchValid}, 32'h1);
    checkOutput("redirPcOut", pcOut, 32'h200);

    // Redirect to 0x103 in the same cycle as the response.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1);
    checkOutput("respPresent", {31'b0, memIf.imem_resp_valid}, 32'h1);
    applyStimulus(1'b0, 1'b1, 32'h103, 1'b1, 1);
    checkOutput("sameCycleReq", {31'b0, memIf.imem_req_valid}, 32'h1);
    checkOutput("sameCycleAddr", memIf.imem_req_addr, 32'h100);
    checkOutput("sameCycleNoStale", {31'b0, fetchValid}, 32'h0);
    guard = 0;
    while (!fetchValid && guard < 10) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1);
      guard++;
    end
    checkOutput("sameCycleFetch", {31'b0, fetchValid}, 32'h1);
    checkOutput("sameCyclePc", pcOut, 32'h100);

    // Asynchronous reset in the middle of WAIT with a slow response.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 6);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 6);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 6);
    checkOutput("midWaitBusy", {31'b0, memBusy}, 32'h1);
    #1 reset = 1'b1;
    #1;
    checkOutput("asyncReqValid", {31'b0, memIf.imem_req_valid}, 32'h0);
    checkOutput("asyncInstr", instrOut, NOP_INSTR);
    checkOutput("asyncPc", pcOut, 32'h0);
    checkOutput("asyncFetchValid", {31'b0, fetchValid}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1);
    checkOutput("postResetReq", {31'b0, memIf.imem_req_valid}, 32'h1);
    checkOutput("postResetAddr", memIf.imem_req_addr, RESET_PC);

    // Randomized stall, redirect, ready and latency.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = $urandom;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      applyStimulus($urandom_range(0, 9) < 3, $urandom_range(0, 99) < 8, tgt,
                    $urandom_range(0, 9) < 7, int'($urandom_range(1, 4)));
    end
    checkOutput("randomProgress", {31'b0, consumed >= 100}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage that produces the PC/instruction pair latched by the IF/ID pipeline register and honours the same `stall` signal that freezes that register. It issues one outstanding request at a time to instruction memory over a valid/ready request and valid response interface. It holds each returned instruction until the pipeline consumes it, and accepts branch/jump redirects that squash in-flight fetches.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- `NOP_INSTR`, 32'h0000_0013, bubble instruction (`addi x0,x0,0`) presented when no instruction is held.

- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `stall` in 1: hazard stall, the same signal that holds IF/ID; 1 = do not consume.
- `redirect_valid` in 1: taken branch/jump from a later stage.
- `redirect_pc` in 32: redirect target; bits [1:0] are ignored and treated as 00.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_addr` out 32: fetch address.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_resp_valid` in 1: response valid. Occurs only for an accepted request, in order, at least 1 cycle after acceptance.
- `imem_resp_data` in 32: fetched instruction.
- `PC_out` out 32: PC of the held instruction; drives IF/ID `PC_in`.
- `instruction_out` out 32: held instruction, or `NOP_INSTR` when none is held; drives IF/ID `instruction_in`.
- `fetch_valid` out 1: a real instruction is held (`buf_valid`).

## Operation
- Internal registers:
  - `fetch_pc` [31:0]: address of the next or outstanding fetch.
  - `buf_valid`, `buf_pc`, `buf_instr`: the holding buffer.
  - `drop_pending`: a stale response is still owed.
  - `state`: IDLE, REQ, WAIT, FULL.
- Outputs are combinational from registers only:
  - `imem_req_valid` = (state==REQ).
  - `imem_req_addr` = `fetch_pc`.
  - `PC_out` = `buf_pc`.
  - `instruction_out` = `buf_valid ? buf_instr : NOP_INSTR`.
  - `fetch_valid` = `buf_valid`.
- Reset values: state=IDLE, `fetch_pc`=`RESET_PC`, `buf_valid`=0, `buf_pc`=0, `buf_instr`=`NOP_INSTR`, `drop_pending`=0. Resulting outputs: `imem_req_valid`=0, `PC_out`=0, `instruction_out`=`NOP_INSTR`.
- State transitions, with no redirect active:
  - IDLE → REQ unconditionally.
  - REQ: on `imem_req_ready` → WAIT.
  - WAIT: on `imem_resp_valid`:
    - If `drop_pending`: discard the response, clear `drop_pending`, → REQ.
    - Otherwise: `buf_pc`←`fetch_pc`, `buf_instr`←`imem_resp_data`, `buf_valid`←1, → FULL.
  - FULL: on `stall`=0, the instruction is consumed (IF/ID captures it at this edge): `buf_valid`←0, `fetch_pc`←`fetch_pc`+4, → REQ. While `stall`=1, hold everything.
- Redirect (`redirect_valid`=1) has highest priority, including during `stall`:
  - Always: `fetch_pc`←{`redirect_pc`[31:2],2'b00}, `buf_valid`←0, and no consumption occurs.
  - IDLE, FULL, or REQ without `imem_req_ready` → REQ.
  - REQ with `imem_req_ready` same cycle: the old-address request is accepted → WAIT, `drop_pending`←1.
  - WAIT without `imem_resp_valid` → WAIT, `drop_pending`←1.
  - WAIT with `imem_resp_valid` same cycle: discard the response, `drop_pending`←0, → REQ.
- Arithmetic: `fetch_pc`+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- At most one request outstanding; no request is issued while in WAIT or FULL.

## Timing
- Minimum loop with `imem_req_ready`=1 and 1-cycle response latency: REQ (accept) → WAIT (response) → FULL (consume) → REQ. That is 3 cycles per instruction with `stall`=0.
- From reset deassertion, the first request is asserted after 1 clock edge (IDLE→REQ).
- Instruction visible on `instruction_out`: the cycle after the `imem_resp_valid` edge.
- Redirect: the new address appears on `imem_req_addr` the cycle after the redirect edge if no stale response is owed. Otherwise it appears the cycle after the stale response arrives.
- While `buf_valid`=0 and `stall`=0, IF/ID captures `NOP_INSTR`, inserting a bubble.
- Asynchronous reset at any point, including WAIT with an outstanding request, returns all state to reset values immediately. The memory must drop any in-flight response on reset.

## Test plan
- Reset release, `RESET_PC`=0, memory always ready with 1-cycle latency returning addr^32'hA5A5_0000 → requests at 0, 4, 8. `PC_out`/`instruction_out` show (0,0xA5A50000), (4,0xA5A50004), (8,0xA5A50008), one every 3 cycles, with `NOP_INSTR` in between.
- `stall`=1 for 4 cycles while FULL at PC 0x10 → `PC_out`=0x10 and the instruction are held. `imem_req_valid`=0 throughout. Next request at 0x14 the cycle after stall drops.
- Redirect to 0x200 while WAIT, response arriving 2 cycles later → that response is discarded and `fetch_valid` stays 0. Next request is at 0x200 and the next `PC_out` is 0x200.
- Redirect to 0x103 in the same cycle as `imem_resp_valid` → response discarded, next request at 0x100, no stale instruction ever presented.
- `RESET_PC`=32'hFFFF_FFFC, consume one instruction → next `imem_req_addr`=32'h0000_0000.
- `reset` asserted mid-WAIT with memory ready stalled low → `imem_req_valid`=0, `instruction_out`=0x00000013, `PC_out`=0 immediately. The first request after release is at `RESET_PC`.
